// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants and types for the instruction store
package imem_pkg;

   localparam logic [15:0] NOP_DEFAULT = 16'h0800;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } imem_state_t;

   // Opcode field layout shared with the decoder
   localparam int          OPC_HI = 15;
   localparam int          OPC_LO = 11;
   localparam logic [4:0]  OP_NOP = 5'b00001;

   function automatic logic [4:0] opcode_of(input logic [15:0] word);
      return word[OPC_HI:OPC_LO];
   endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - instruction storage, synchronous write and combinational read
module imem_array #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 64,
   parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_store.sv
// rtl/instruction_store.sv - writable instruction memory with init clear, loader port and fetch register
module instruction_store
   import imem_pkg::*;
#(
   parameter int                DATA_W     = 16,
   parameter int                DEPTH      = 64,
   parameter int                PC_W       = 16,
   parameter int                ADDR_SHIFT = 2,
   parameter logic [DATA_W-1:0] NOP_WORD   = NOP_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PC_W-1:0]   pc,
   input  logic              fetch_en,
   input  logic              stall,
   input  logic              flush,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   input  logic              wr_en,
   input  logic [PC_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic              busy
);

   localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PC_W-1:0] DEPTH_PC = PC_W'(DEPTH);

   imem_state_t       state;
   logic [AW-1:0]     counter;
   logic [AW:0]       hi_water;

   logic [PC_W-1:0]   idx;
   logic              wr_store;
   logic [AW:0]       wr_top;
   logic [AW:0]       hi_eff;
   logic              fetch_acc;
   logic              fetch_in_range;
   logic              bypass;
   logic [DATA_W-1:0] fetch_word;

   logic              a_we;
   logic [AW-1:0]     a_waddr;
   logic [DATA_W-1:0] a_wdata;
   logic [DATA_W-1:0] rd_data;

   assign idx      = pc >> ADDR_SHIFT;
   assign wr_store = wr_en && wr_ready && (wr_addr < DEPTH_PC);
   assign wr_top   = {1'b0, wr_addr[AW-1:0]} + (AW+1)'(1);
   // The range check sees this cycle's write so a bypassed word is not masked to NOP
   assign hi_eff   = (wr_store && (wr_top > hi_water)) ? wr_top : hi_water;

   assign fetch_acc      = (state == RUN) && fetch_en && !stall && !flush;
   assign fetch_in_range = (idx < DEPTH_PC) && (idx < PC_W'(hi_eff));
   assign bypass         = wr_store && (wr_addr == idx);

   always_comb begin
      fetch_word = NOP_WORD;
      if (fetch_in_range) begin
         fetch_word = bypass ? wr_data : rd_data;
      end
   end

   assign a_we    = !rst && ((state == INIT) || wr_store);
   assign a_waddr = (state == INIT) ? counter  : wr_addr[AW-1:0];
   assign a_wdata = (state == INIT) ? NOP_WORD : wr_data;

   imem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_array (
      .clk   (clk),
      .we    (a_we),
      .waddr (a_waddr),
      .wdata (a_wdata),
      .raddr (idx[AW-1:0]),
      .rdata (rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= INIT;
         counter  <= '0;
         hi_water <= '0;
         busy     <= 1'b1;
         wr_ready <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               counter <= counter + AW'(1);
               if (counter == AW'(DEPTH - 1)) begin
                  state    <= RUN;
                  busy     <= 1'b0;
                  wr_ready <= 1'b1;
               end
            end
            RUN: begin
               if (wr_store) begin
                  hi_water <= hi_eff;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr       <= NOP_WORD;
         instr_valid <= 1'b0;
      end else if (flush) begin
         instr       <= NOP_WORD;
         instr_valid <= 1'b0;
      end else if (stall) begin
         instr       <= instr;
         instr_valid <= instr_valid;
      end else if (fetch_acc) begin
         instr       <= fetch_word;
         instr_valid <= 1'b1;
      end else begin
         instr_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instruction_store.sv
// tb/tb_instruction_store.sv - directed scoreboard bench for instruction_store
module tb_instruction_store;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] pc;
   logic        fetch_en;
   logic        stall;
   logic        flush;
   logic [15:0] instr;
   logic        instr_valid;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   logic        wr_ready;
   logic        busy;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   string       tag_q[$];
   logic [16:0] exp_q[$];

   always #5 clk = ~clk;

   instruction_store dut (
      .clk         (clk),
      .rst         (rst),
      .pc          (pc),
      .fetch_en    (fetch_en),
      .stall       (stall),
      .flush       (flush),
      .instr       (instr),
      .instr_valid (instr_valid),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic fe, input logic [15:0] p, input logic st, input logic fl,
                        input logic we, input logic [15:0] wa, input logic [15:0] wd);
      fetch_en = fe;
      pc       = p;
      stall    = st;
      flush    = fl;
      wr_en    = we;
      wr_addr  = wa;
      wr_data  = wd;
   endtask

   task automatic expect_out(input string tag, input logic [15:0] ins, input logic v);
      tag_q.push_back(tag);
      exp_q.push_back({v, ins});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
         string       t;
         logic [16:0] e;
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         check({t, "_instr"}, 32'(instr), 32'(e[15:0]));
         check({t, "_valid"}, 32'(instr_valid), 32'(e[16]));
      end
   endtask

   task automatic count_busy(input string tag, input int expected);
      int   cnt;
      logic ready_seen;
      cnt        = 0;
      ready_seen = 1'b0;
      while (busy === 1'b1 && cnt < 200) begin
         if (wr_ready !== 1'b0) ready_seen = 1'b1;
         cnt++;
         tick();
      end
      check({tag, "_busy_cycles"}, 32'(cnt), 32'(expected));
      check({tag, "_wr_ready_low"}, 32'(ready_seen), 32'd0);
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
      check({tag, "_wr_ready_up"}, 32'(wr_ready), 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
      tick();
      tick();
      check("reset_instr", 32'(instr), 32'h0800);
      check("reset_valid", 32'(instr_valid), 32'd0);
      check("reset_busy", 32'(busy), 32'd1);
      check("reset_wr_ready", 32'(wr_ready), 32'd0);

      rst = 1'b0;
      count_busy("init", 64);

      drive(1, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
      expect_out("fetch_cleared", 16'h0800, 1'b1);
      tick();

      drive(0, 16'h0000, 0, 0, 1, 16'h0000, 16'h4907);
      expect_out("idle_wr0", 16'h0800, 1'b0);
      tick();
      drive(0, 16'h0000, 0, 0, 1, 16'h0001, 16'h6ACF);
      expect_out("idle_wr1", 16'h0800, 1'b0);
      tick();

      drive(1, 16'h0004, 0, 0, 0, 16'h0000, 16'h0000);
      expect_out("fetch_idx1", 16'h6ACF, 1'b1);
      tick();
      drive(1, 16'h0008, 0, 0, 0, 16'h0000, 16'h0000);
      expect_out("fetch_above_hiwater", 16'h0800, 1'b1);
      tick();

      drive(1, 16'h000C, 0, 0, 1, 16'h0003, 16'h3340);
      expect_out("bypass", 16'h3340, 1'b1);
      tick();

      drive(1, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
      expect_out("fetch_idx0", 16'h4907, 1'b1);
      tick();
      for (int i = 1; i <= 3; i++) begin
         drive(1, 16'(i * 4), 1, 0, 0, 16'h0000, 16'h0000);
         expect_out("stall_hold", 16'h4907, 1'b1);
         tick();
      end
      drive(1, 16'h0004, 1, 1, 0, 16'h0000, 16'h0000);
      expect_out("flush_stall", 16'h0800, 1'b0);
      tick();

      drive(1, 16'h0100, 0, 0, 0, 16'h0000, 16'h0000);
      expect_out("fetch_idx64", 16'h0800, 1'b1);
      tick();
      drive(0, 16'h0000, 0, 0, 1, 16'h0040, 16'hFFFF);
      expect_out("idle_wr64", 16'h0800, 1'b0);
      tick();
      drive(1, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
      expect_out("fetch_after_drop", 16'h4907, 1'b1);
      tick();
      drive(0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
      expect_out("idle_hold", 16'h4907, 1'b0);
      tick();

      rst = 1'b1;
      expect_out("run_reset", 16'h0800, 1'b0);
      tick();
      check("run_reset_busy", 32'(busy), 32'd1);
      check("run_reset_wr_ready", 32'(wr_ready), 32'd0);
      rst = 1'b0;
      // Fetches and writes during the clear must be ignored
      for (int i = 0; i < 30; i++) begin
         drive(1, 16'h0000, 0, 0, 1, 16'h0000, 16'h1234);
         expect_out("init_ignored", 16'h0800, 1'b0);
         tick();
      end
      drive(0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      count_busy("reinit", 64);

      drive(1, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
      expect_out("fetch_after_reset", 16'h0800, 1'b1);
      tick();
      drive(0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/instruction_store.md
# instruction_store

Parametrised, writable instruction memory for the 16-bit pipelined CPU. It replaces the fixed test-program ROM in the IF stage. The block clears itself to NOP after reset, accepts program words from a loader port (serial/bootloader path), and serves registered fetches with stall and flush control. Fetches beyond the loaded program return NOP.

## Interface
- DATA_W, 16, instruction word width
- DEPTH, 64, number of instruction words; power of two, ≥ 2
- PC_W, 16, width of pc and wr_addr
- ADDR_SHIFT, 2, word index = pc >> ADDR_SHIFT
- NOP_WORD, 16'h0800, value returned for empty or out-of-range words

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pc  in  PC_W  fetch address
- fetch_en  in  1  request a fetch of pc this cycle
- stall  in  1  hold instr/instr_valid unchanged
- flush  in  1  kill the output word
- instr  out  DATA_W  fetched instruction
- instr_valid  out  1  instr is the result of an accepted fetch
- wr_en  in  1  loader write strobe
- wr_addr  in  PC_W  loader word index (not shifted)
- wr_data  in  DATA_W  loader word
- wr_ready  out  1  write is accepted when wr_en && wr_ready
- busy  out  1  init clear in progress

## Operation
- States: INIT, RUN. Reset forces INIT, clear counter = 0, hi_water = 0.
- INIT: writes NOP_WORD to entry `counter`, counter++. After entry DEPTH-1 is written, the block moves to RUN. busy=1, wr_ready=0. fetch_en and wr_en are ignored.
- RUN: busy=0, wr_ready=1. There is no return to INIT except through rst.
- Write: an accepted write with wr_addr < DEPTH stores mem[wr_addr] = wr_data and sets hi_water = max(hi_water, wr_addr+1). A write with wr_addr ≥ DEPTH is dropped silently, and hi_water is unchanged.
- Fetch: idx = pc >> ADDR_SHIFT. A fetch is accepted when in RUN && fetch_en && !stall && !flush.
  - If idx < DEPTH and idx < hi_water, the result is mem[idx].
  - Otherwise the result is NOP_WORD.
  - There is no modulo wrap.
- Same-cycle write and fetch to the same idx: the fetch returns wr_data (write bypass). hi_water counts the write for the range check.
- Priority on the output register: rst > flush > stall > accepted fetch > idle.
  - flush: instr = NOP_WORD, instr_valid = 0.
  - stall: instr and instr_valid are held.
  - idle (fetch_en=0 or INIT): instr_valid = 0, instr is held.
- Writes proceed during stall and flush.

## Timing
- Reset values: instr = NOP_WORD, instr_valid = 0, busy = 1, wr_ready = 0.
- Init duration: exactly DEPTH cycles after the first clock edge with rst=0. busy falls on the edge that completes the last clear.
- Fetch latency is 1 cycle. A fetch accepted at edge N appears on instr/instr_valid after edge N, and stays valid for one cycle unless stalled.
- Writes take effect on the accepting edge. A fetch of that word in the next cycle returns the new data.
- rst asserted mid-INIT or mid-RUN restarts INIT from counter 0 on the next edge. Loaded contents are lost (cleared) and hi_water returns to 0.

## Structure
- Package imem_pkg holds:
  - the NOP_WORD default (16'h0800)
  - the state enum {INIT, RUN}
  - the opcode field constants shared with the decoder
- Sub-module imem_array holds the storage: a synchronous write port, a combinational read port, and DEPTH × DATA_W storage.
- The top level holds the FSM, clear counter, hi_water, range check, bypass, and output register.

## Test plan
- **Reset and init clear:** after rst, count cycles → busy = 1 for exactly 64 cycles, wr_ready = 0 throughout. Then fetch pc=0x0000 → instr = 0x0800, instr_valid = 1 one cycle later.
- **Load then fetch:** write idx0 = 0x4907, idx1 = 0x6ACF.
  - Fetch pc=0x0004 → 0x6ACF next cycle.
  - Fetch pc=0x0008 → 0x0800 (idx 2 ≥ hi_water 2).
- **Bypass:** in the same cycle, write idx3 = 0x3340 and fetch pc=0x000C → instr = 0x3340 next cycle.
- **Stall and flush:**
  - Fetch pc=0x0000 (0x4907), then stall 3 cycles while pc changes → instr holds 0x4907 with valid = 1.
  - Assert flush together with stall → instr = 0x0800, valid = 0.
- **Out-of-range:**
  - Fetch pc=0x0100 (idx 64) → 0x0800.
  - Write idx 64 = 0xFFFF → dropped. A subsequent fetch of pc=0x0000 still returns 0x4907, and hi_water is unchanged.
- **Reset mid-operation:**
  - rst at clear counter 30 → busy lasts a full 64 cycles afterward.
  - rst after loading idx0 → after init, fetch pc=0x0000 returns 0x0800.
